// File: rtl/rv32_alu_pkg.sv
// Shared ALU op codes, opcodes and select encodings
// for the RV32IM ID->EX issue path.
package rv32_alu_pkg;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] ALU_AND    = 5'd0;
  localparam logic [OPW-1:0] ALU_OR     = 5'd1;
  localparam logic [OPW-1:0] ALU_ADD    = 5'd2;
  localparam logic [OPW-1:0] ALU_SUB    = 5'd3;
  localparam logic [OPW-1:0] ALU_SLL    = 5'd4;
  localparam logic [OPW-1:0] ALU_SLT    = 5'd5;
  localparam logic [OPW-1:0] ALU_SLTU   = 5'd6;
  localparam logic [OPW-1:0] ALU_XOR    = 5'd7;
  localparam logic [OPW-1:0] ALU_SRL    = 5'd8;
  localparam logic [OPW-1:0] ALU_SRA    = 5'd9;
  localparam logic [OPW-1:0] ALU_MUL    = 5'd10;
  localparam logic [OPW-1:0] ALU_MULH   = 5'd11;
  localparam logic [OPW-1:0] ALU_MULHSU = 5'd12;
  localparam logic [OPW-1:0] ALU_MULHU  = 5'd13;
  localparam logic [OPW-1:0] ALU_DIV    = 5'd14;
  localparam logic [OPW-1:0] ALU_DIVU   = 5'd15;
  localparam logic [OPW-1:0] ALU_REM    = 5'd16;
  localparam logic [OPW-1:0] ALU_REMU   = 5'd17;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [1:0] FWD_RS    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_RS_2  = 2'b11;

  typedef enum logic [1:0] {
    A_ZERO, A_RS1, A_PC
  } a_sel_e;

  typedef enum logic [1:0] {
    B_ZERO, B_RS2, B_IMM, B_FOUR
  } b_sel_e;

  function automatic logic [OPW-1:0] base_op(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [OPW-1:0] op;
    unique case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct decode into ALU op
// and operand source selects.
module alu_op_decode
  import rv32_alu_pkg::*;
(
  input  logic [6:0]     opcode,
  input  logic [2:0]     funct3,
  input  logic [6:0]     funct7,
  output logic [OPW-1:0] alu_op,
  output a_sel_e         a_sel,
  output b_sel_e         b_sel,
  output logic           illegal
);

  // decode; any illegal encoding collapses to ADD 0,0
  always_comb begin
    alu_op  = ALU_ADD;
    a_sel   = A_ZERO;
    b_sel   = B_ZERO;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        a_sel = A_RS1;
        b_sel = B_RS2;
        if (funct7 == F7_MUL)
          alu_op = ALU_MUL + {2'b00, funct3};
        else if (funct7 == F7_BASE)
          alu_op = base_op(funct3, 1'b0);
        else if (funct7 == F7_ALT &&
                 (funct3 == 3'b000 ||
                  funct3 == 3'b101))
          alu_op = base_op(funct3, 1'b1);
        else
          illegal = 1'b1;
      end
      OP_I: begin
        a_sel = A_RS1;
        b_sel = B_IMM;
        case (funct3)
          3'b001: begin
            alu_op  = ALU_SLL;
            illegal = (funct7 != F7_BASE);
          end
          3'b101: begin
            if (funct7 == F7_BASE)
              alu_op = ALU_SRL;
            else if (funct7 == F7_ALT)
              alu_op = ALU_SRA;
            else
              illegal = 1'b1;
          end
          default:
            alu_op = base_op(funct3, 1'b0);
        endcase
      end
      OP_LUI: begin
        b_sel = B_IMM;
      end
      OP_AUIPC: begin
        a_sel = A_PC;
        b_sel = B_IMM;
      end
      OP_LOAD, OP_STORE: begin
        a_sel = A_RS1;
        b_sel = B_IMM;
      end
      OP_JAL, OP_JALR: begin
        a_sel = A_PC;
        b_sel = B_FOUR;
      end
      OP_BRANCH: begin
        a_sel  = A_RS1;
        b_sel  = B_RS2;
        alu_op = ALU_SUB;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      alu_op = ALU_ADD;
      a_sel  = A_ZERO;
      b_sel  = B_ZERO;
    end
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID->EX issue stage: forwarding, operand select
// and the stall/flush controlled pipeline register.
module id_ex_alu_issue
  import rv32_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESETN,
  input  logic            STALL,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  input  logic [6:0]      OPCODE,
  input  logic [2:0]      FUNCT3,
  input  logic [6:0]      FUNCT7,
  input  logic [4:0]      RD_IN,
  input  logic [XLEN-1:0] PC_IN,
  input  logic [XLEN-1:0] RS1_DATA,
  input  logic [XLEN-1:0] RS2_DATA,
  input  logic [XLEN-1:0] IMM,
  input  logic [1:0]      FWD_A_SEL,
  input  logic [1:0]      FWD_B_SEL,
  input  logic [XLEN-1:0] EXMEM_RESULT,
  input  logic [XLEN-1:0] MEMWB_RESULT,
  output logic [XLEN-1:0] DATA1,
  output logic [XLEN-1:0] DATA2,
  output logic [OPW-1:0]  ALU_OPERATION,
  output logic [XLEN-1:0] STORE_DATA,
  output logic [4:0]      RD_OUT,
  output logic            OUT_VALID,
  output logic            ILLEGAL
);

  logic [OPW-1:0]  dec_op;
  a_sel_e          dec_a;
  b_sel_e          dec_b;
  logic            dec_ill;
  logic [XLEN-1:0] fwd_a, fwd_b;
  logic [XLEN-1:0] opnd_a, opnd_b;

  logic [XLEN-1:0] data1_d, data1_q;
  logic [XLEN-1:0] data2_d, data2_q;
  logic [OPW-1:0]  op_d, op_q;
  logic [XLEN-1:0] sdata_d, sdata_q;
  logic [4:0]      rd_d, rd_q;
  logic            valid_d, valid_q;
  logic            ill_d, ill_q;

  alu_op_decode u_dec (
    .opcode  (OPCODE),
    .funct3  (FUNCT3),
    .funct7  (FUNCT7),
    .alu_op  (dec_op),
    .a_sel   (dec_a),
    .b_sel   (dec_b),
    .illegal (dec_ill)
  );

  // forwarding muxes for rs1/rs2
  always_comb begin
    unique case (FWD_A_SEL)
      FWD_EXMEM: fwd_a = EXMEM_RESULT;
      FWD_MEMWB: fwd_a = MEMWB_RESULT;
      default:   fwd_a = RS1_DATA;
    endcase
    unique case (FWD_B_SEL)
      FWD_EXMEM: fwd_b = EXMEM_RESULT;
      FWD_MEMWB: fwd_b = MEMWB_RESULT;
      default:   fwd_b = RS2_DATA;
    endcase
  end

  // operand source muxes
  always_comb begin
    unique case (dec_a)
      A_RS1:   opnd_a = fwd_a;
      A_PC:    opnd_a = PC_IN;
      default: opnd_a = '0;
    endcase
    unique case (dec_b)
      B_RS2:   opnd_b = fwd_b;
      B_IMM:   opnd_b = IMM;
      B_FOUR:  opnd_b = XLEN'(4);
      default: opnd_b = '0;
    endcase
  end

  // next state: flush > stall > load
  always_comb begin
    data1_d = data1_q;
    data2_d = data2_q;
    op_d    = op_q;
    sdata_d = sdata_q;
    rd_d    = rd_q;
    valid_d = valid_q;
    ill_d   = ill_q;
    if (FLUSH) begin
      data1_d = '0;
      data2_d = '0;
      op_d    = ALU_ADD;
      sdata_d = '0;
      rd_d    = '0;
      valid_d = 1'b0;
      ill_d   = 1'b0;
    end else if (!STALL) begin
      data1_d = opnd_a;
      data2_d = opnd_b;
      op_d    = dec_op;
      sdata_d = fwd_b;
      rd_d    = RD_IN;
      valid_d = IN_VALID;
      ill_d   = IN_VALID & dec_ill;
    end
  end

  // pipeline register, async clear
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      data1_q <= '0;
      data2_q <= '0;
      op_q    <= '0;
      sdata_q <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      data1_q <= data1_d;
      data2_q <= data2_d;
      op_q    <= op_d;
      sdata_q <= sdata_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
    end
  end

  assign DATA1         = data1_q;
  assign DATA2         = data2_q;
  assign ALU_OPERATION = op_q;
  assign STORE_DATA    = sdata_q;
  assign RD_OUT        = rd_q;
  assign OUT_VALID     = valid_q;
  assign ILLEGAL       = ill_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Bench for id_ex_alu_issue: directed table,
// corner sequences, random vs reference model.
module tb_id_ex_alu_issue;

  logic        CLK = 1'b0;
  logic        RESETN, STALL, FLUSH, IN_VALID;
  logic [6:0]  OPCODE, FUNCT7;
  logic [2:0]  FUNCT3;
  logic [4:0]  RD_IN;
  logic [31:0] PC_IN, RS1_DATA, RS2_DATA, IMM;
  logic [1:0]  FWD_A_SEL, FWD_B_SEL;
  logic [31:0] EXMEM_RESULT, MEMWB_RESULT;
  logic [31:0] DATA1, DATA2, STORE_DATA;
  logic [4:0]  ALU_OPERATION, RD_OUT;
  logic        OUT_VALID, ILLEGAL;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_alu_issue dut (
    .CLK(CLK), .RESETN(RESETN), .STALL(STALL),
    .FLUSH(FLUSH), .IN_VALID(IN_VALID),
    .OPCODE(OPCODE), .FUNCT3(FUNCT3),
    .FUNCT7(FUNCT7), .RD_IN(RD_IN), .PC_IN(PC_IN),
    .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
    .IMM(IMM), .FWD_A_SEL(FWD_A_SEL),
    .FWD_B_SEL(FWD_B_SEL),
    .EXMEM_RESULT(EXMEM_RESULT),
    .MEMWB_RESULT(MEMWB_RESULT),
    .DATA1(DATA1), .DATA2(DATA2),
    .ALU_OPERATION(ALU_OPERATION),
    .STORE_DATA(STORE_DATA), .RD_OUT(RD_OUT),
    .OUT_VALID(OUT_VALID), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  // expected register contents
  logic [31:0] e_d1, e_d2, e_sd;
  logic [4:0]  e_op, e_rd;
  logic        e_v, e_ill;
  bit          side_known;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } dec_t;

  function automatic logic [31:0] fwd(
    input logic [1:0] s, input logic [31:0] rs);
    if (s == 2'd1) return EXMEM_RESULT;
    if (s == 2'd2) return MEMWB_RESULT;
    return rs;
  endfunction

  function automatic dec_t ref_dec();
    dec_t r;
    int base [8] = '{2, 4, 5, 6, 7, 8, 1, 0};
    logic [31:0] fa, fb;
    fa = fwd(FWD_A_SEL, RS1_DATA);
    fb = fwd(FWD_B_SEL, RS2_DATA);
    r.op = 5'd2; r.a = 0; r.b = 0; r.ill = 1'b0;
    case (OPCODE)
      7'h33: begin
        r.a = fa; r.b = fb;
        if (FUNCT7 == 7'h01)
          r.op = 5'(10 + int'(FUNCT3));
        else if (FUNCT7 == 7'h00)
          r.op = 5'(base[FUNCT3]);
        else if (FUNCT7 == 7'h20 && FUNCT3 == 3'd0)
          r.op = 5'd3;
        else if (FUNCT7 == 7'h20 && FUNCT3 == 3'd5)
          r.op = 5'd9;
        else r.ill = 1'b1;
      end
      7'h13: begin
        r.a = fa; r.b = IMM;
        if (FUNCT3 == 3'd1) begin
          r.op = 5'd4;
          r.ill = (FUNCT7 != 7'h00);
        end else if (FUNCT3 == 3'd5) begin
          if (FUNCT7 == 7'h00) r.op = 5'd8;
          else if (FUNCT7 == 7'h20) r.op = 5'd9;
          else r.ill = 1'b1;
        end else r.op = 5'(base[FUNCT3]);
      end
      7'h37: r.b = IMM;
      7'h17: begin r.a = PC_IN; r.b = IMM; end
      7'h03, 7'h23: begin r.a = fa; r.b = IMM; end
      7'h6f, 7'h67: begin r.a = PC_IN; r.b = 4; end
      7'h63: begin r.a = fa; r.b = fb; r.op = 5'd3; end
      default: r.ill = 1'b1;
    endcase
    if (r.ill) begin
      r.op = 5'd2; r.a = 0; r.b = 0;
    end
    return r;
  endfunction

  task automatic model_reset();
    e_d1 = 0; e_d2 = 0; e_sd = 0; e_op = 0;
    e_rd = 0; e_v = 0; e_ill = 0; side_known = 1;
  endtask

  // what the next rising edge must do
  task automatic model_edge();
    dec_t d;
    if (FLUSH) begin
      e_d1 = 0; e_d2 = 0; e_op = 5'd2;
      e_v = 0; e_ill = 0; side_known = 0;
    end else if (!STALL) begin
      d = ref_dec();
      e_d1 = d.a; e_d2 = d.b; e_op = d.op;
      e_sd = fwd(FWD_B_SEL, RS2_DATA);
      e_rd = RD_IN; e_v = IN_VALID;
      e_ill = IN_VALID & d.ill; side_known = 1;
    end
  endtask

  task automatic chk(input string nm,
    input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " DATA1"}, DATA1, e_d1);
    chk({tag, " DATA2"}, DATA2, e_d2);
    chk({tag, " ALU_OP"}, 32'(ALU_OPERATION),
        32'(e_op));
    chk({tag, " OUT_VALID"}, 32'(OUT_VALID), 32'(e_v));
    chk({tag, " ILLEGAL"}, 32'(ILLEGAL), 32'(e_ill));
    if (side_known) begin
      chk({tag, " STORE_DATA"}, STORE_DATA, e_sd);
      chk({tag, " RD_OUT"}, 32'(RD_OUT), 32'(e_rd));
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic rand_inputs();
    logic [6:0] opcs [10] = '{7'h33, 7'h13, 7'h37,
      7'h17, 7'h03, 7'h23, 7'h6f, 7'h67, 7'h63, 7'h7f};
    int k;
    k = int'($urandom_range(0, 10));
    OPCODE = (k == 10) ? 7'($urandom) : opcs[k];
    FUNCT3 = 3'($urandom);
    k = int'($urandom_range(0, 3));
    FUNCT7 = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 :
             (k == 2) ? 7'h01 : 7'($urandom);
    RD_IN = 5'($urandom);
    PC_IN = $urandom; IMM = $urandom;
    RS1_DATA = $urandom; RS2_DATA = $urandom;
    EXMEM_RESULT = $urandom; MEMWB_RESULT = $urandom;
    FWD_A_SEL = 2'($urandom); FWD_B_SEL = 2'($urandom);
    IN_VALID = ($urandom_range(0, 3) != 0);
  endtask

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1, rs2, imm, pc;
    logic [1:0]  fa, fb;
    logic [31:0] exm, mwb;
    logic [4:0]  x_op;
    logic [31:0] x_d1, x_d2, x_sd;
    logic        x_ill;
  } vec_t;

  vec_t vt [13];

  initial begin
    vt[0]  = '{7'h33, 3'd0, 7'h20, 32'hA5A5A5A5,
      32'h5A5A5A5A, 0, 0, 2'd0, 2'd0, 0, 0,
      5'd3, 32'hA5A5A5A5, 32'h5A5A5A5A,
      32'h5A5A5A5A, 1'b0};
    vt[1]  = '{7'h33, 3'd6, 7'h01, 32'h11, 32'h22,
      0, 0, 2'd0, 2'd0, 0, 0,
      5'd16, 32'h11, 32'h22, 32'h22, 1'b0};
    vt[2]  = '{7'h13, 3'd5, 7'h20, 32'h80000000, 7,
      5, 0, 2'd0, 2'd0, 0, 0,
      5'd9, 32'h80000000, 32'd5, 32'd7, 1'b0};
    vt[3]  = '{7'h17, 3'd0, 7'h00, 3, 4, 32'h2000,
      32'h1000, 2'd0, 2'd0, 0, 0,
      5'd2, 32'h1000, 32'h2000, 32'd4, 1'b0};
    vt[4]  = '{7'h33, 3'd0, 7'h00, 1, 2, 0, 0,
      2'd1, 2'd0, 32'hDEADBEEF, 0,
      5'd2, 32'hDEADBEEF, 32'd2, 32'd2, 1'b0};
    vt[5]  = '{7'h23, 3'd2, 7'h00, 32'h100, 9, 8, 0,
      2'd0, 2'd2, 0, 32'hCAFEF00D,
      5'd2, 32'h100, 32'd8, 32'hCAFEF00D, 1'b0};
    vt[6]  = '{7'h7f, 3'd0, 7'h00, 5, 6, 7, 0,
      2'd0, 2'd0, 0, 0,
      5'd2, 32'd0, 32'd0, 32'd6, 1'b1};
    vt[7]  = '{7'h6f, 3'd0, 7'h00, 1, 3, 0, 32'h400,
      2'd0, 2'd0, 0, 0,
      5'd2, 32'h400, 32'd4, 32'd3, 1'b0};
    vt[8]  = '{7'h37, 3'd0, 7'h00, 32'h77, 1,
      32'h12345000, 0, 2'd0, 2'd0, 0, 0,
      5'd2, 32'd0, 32'h12345000, 32'd1, 1'b0};
    vt[9]  = '{7'h63, 3'd1, 7'h00, 9, 3, 0, 0,
      2'd0, 2'd0, 0, 0,
      5'd3, 32'd9, 32'd3, 32'd3, 1'b0};
    vt[10] = '{7'h13, 3'd1, 7'h20, 9, 3, 1, 0,
      2'd0, 2'd0, 0, 0,
      5'd2, 32'd0, 32'd0, 32'd3, 1'b1};
    vt[11] = '{7'h33, 3'd1, 7'h20, 9, 3, 1, 0,
      2'd0, 2'd0, 0, 0,
      5'd2, 32'd0, 32'd0, 32'd3, 1'b1};
    vt[12] = '{7'h33, 3'd7, 7'h00, 32'hF0, 32'h3C, 0, 0,
      2'd3, 2'd3, 32'h1, 32'h2,
      5'd0, 32'hF0, 32'h3C, 32'h3C, 1'b0};

    RESETN = 0; STALL = 0; FLUSH = 0; IN_VALID = 0;
    OPCODE = 0; FUNCT3 = 0; FUNCT7 = 0; RD_IN = 0;
    PC_IN = 0; RS1_DATA = 0; RS2_DATA = 0; IMM = 0;
    FWD_A_SEL = 0; FWD_B_SEL = 0;
    EXMEM_RESULT = 0; MEMWB_RESULT = 0;
    model_reset();
    @(posedge CLK); #1;
    check_all("reset");
    @(posedge CLK); #1;
    RESETN = 1;

    // directed table
    for (int i = 0; i < 13; i++) begin
      OPCODE = vt[i].opc; FUNCT3 = vt[i].f3;
      FUNCT7 = vt[i].f7; RS1_DATA = vt[i].rs1;
      RS2_DATA = vt[i].rs2; IMM = vt[i].imm;
      PC_IN = vt[i].pc; FWD_A_SEL = vt[i].fa;
      FWD_B_SEL = vt[i].fb; EXMEM_RESULT = vt[i].exm;
      MEMWB_RESULT = vt[i].mwb; IN_VALID = 1;
      RD_IN = 5'(i + 1);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl_op", i),
          32'(ALU_OPERATION), 32'(vt[i].x_op));
      chk($sformatf("vec%0d tbl_d1", i),
          DATA1, vt[i].x_d1);
      chk($sformatf("vec%0d tbl_d2", i),
          DATA2, vt[i].x_d2);
      chk($sformatf("vec%0d tbl_sd", i),
          STORE_DATA, vt[i].x_sd);
      chk($sformatf("vec%0d tbl_ill", i),
          32'(ILLEGAL), 32'(vt[i].x_ill));
      chk($sformatf("vec%0d tbl_v", i),
          32'(OUT_VALID), 32'd1);
    end

    // stall held 3 cycles while inputs change
    OPCODE = 7'h33; FUNCT3 = 3'd4; FUNCT7 = 7'h00;
    RS1_DATA = 32'h1234; RS2_DATA = 32'h5678;
    FWD_A_SEL = 0; FWD_B_SEL = 0; IN_VALID = 1;
    step("pre_stall");
    STALL = 1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      step($sformatf("stall%0d", i));
      chk($sformatf("stall%0d held_d1", i),
          DATA1, 32'h1234);
    end
    FLUSH = 1;
    step("flush_stall");
    chk("flush_stall op", 32'(ALU_OPERATION), 32'd2);
    chk("flush_stall v", 32'(OUT_VALID), 32'd0);
    STALL = 0; FLUSH = 0;

    // invalid instruction loads data, not valid
    OPCODE = 7'h7f; IN_VALID = 0;
    step("inv_illegal");
    chk("inv_illegal ill", 32'(ILLEGAL), 32'd0);

    // async reset mid-cycle
    OPCODE = 7'h37; IMM = 32'hABCD0000; IN_VALID = 1;
    step("pre_rst");
    #2 RESETN = 0;
    model_reset();
    #1 check_all("async_rst");
    RESETN = 1;
    OPCODE = 7'h17; PC_IN = 32'h80; IMM = 32'h10;
    step("post_rst");

    // randomized
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      STALL = ($urandom_range(0, 7) == 0);
      FLUSH = ($urandom_range(0, 9) == 0);
      step($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
